// File: rtl/ddr_rd_cmd_responder.sv
// Purpose: burst read-command responder; queues commands, issues per-word memory reads, returns words in order.
// Latency: accept at edge T -> mem_rd_en in cycle T+2 -> ddr_rd_data_valid in cycle T+3+MEM_LATENCY; 1 word/cycle sustained.
// Backpressure: ddr_cmd_ready drops only when the command FIFO is full; return path has none. Optional stats: DDR_RSP_STATS_EN.
module ddr_rd_cmd_responder #(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int MEM_LATENCY    = 2,
    parameter int DATA_W         = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ddr_cmd_valid,
    input  logic [31:0]       ddr_cmd_base_adr,
    input  logic [15:0]       ddr_cmd_length,
    output logic              ddr_cmd_ready,
    output logic              mem_rd_en,
    output logic [31:0]       mem_rd_adr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] ddr_rd_data,
    output logic              ddr_rd_data_valid,
    output logic              cmd_err,
    output logic              busy
`ifdef DDR_RSP_STATS_EN
    ,
    output logic [31:0]       stat_cmd_count,
    output logic [31:0]       stat_word_count
`endif
);

    localparam int AW = $clog2(CMD_FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    // command FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [31:0]      fifo_base [CMD_FIFO_DEPTH];
    logic [15:0]      fifo_len  [CMD_FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty, push, pop;
    logic [31:0]      head_base;
    logic [15:0]      head_len;

    state_t           state, state_nxt;
    logic [31:0]      cur_adr, cur_adr_nxt;
    logic [15:0]      remaining, remaining_nxt;
    logic             issue, err;
    logic [MEM_LATENCY-1:0] vld_pipe;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign ddr_cmd_ready = !fifo_full;
    assign push          = ddr_cmd_valid && !fifo_full;
    assign head_base     = fifo_base[rd_ptr[AW-1:0]];
    assign head_len      = fifo_len[rd_ptr[AW-1:0]];

    // FIFO payload write; storage needs no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_base[wr_ptr[AW-1:0]] <= ddr_cmd_base_adr;
            fifo_len[wr_ptr[AW-1:0]]  <= ddr_cmd_length;
        end
    end

    // FIFO pointer update; a pop never frees a slot for a same-cycle push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM state and burst counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_adr   <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            cur_adr   <= cur_adr_nxt;
            remaining <= remaining_nxt;
        end
    end

    // next-state: pop/load in IDLE, issue words in ISSUE, chain into next burst without a bubble
    always_comb begin
        state_nxt     = state;
        cur_adr_nxt   = cur_adr;
        remaining_nxt = remaining;
        pop           = 1'b0;
        issue         = 1'b0;
        err           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_len == 16'd0) begin
                        err = 1'b1;
                    end else begin
                        cur_adr_nxt   = head_base;
                        remaining_nxt = head_len;
                        state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                issue         = 1'b1;
                cur_adr_nxt   = cur_adr + 32'd1;
                remaining_nxt = remaining - 16'd1;
                if (remaining == 16'd1) begin
                    // zero-length heads are left for IDLE so cmd_err is raised there
                    if (!fifo_empty && head_len != 16'd0) begin
                        pop           = 1'b1;
                        cur_adr_nxt   = head_base;
                        remaining_nxt = head_len;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // registered memory strobe/address and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_en  <= 1'b0;
            mem_rd_adr <= '0;
            cmd_err    <= 1'b0;
        end else begin
            mem_rd_en <= issue;
            if (issue) mem_rd_adr <= cur_adr;
            cmd_err   <= err;
        end
    end

    // valid pipeline tracking memory latency; tail stage marks mem_rd_data as valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // capture returned word; data holds when no strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ddr_rd_data       <= '0;
            ddr_rd_data_valid <= 1'b0;
        end else begin
            if (vld_pipe[MEM_LATENCY-1]) ddr_rd_data <= mem_rd_data;
            ddr_rd_data_valid <= vld_pipe[MEM_LATENCY-1];
        end
    end

    assign busy = !fifo_empty || (state == ISSUE) || mem_rd_en || (|vld_pipe) || ddr_rd_data_valid;

`ifdef DDR_RSP_STATS_EN
    // command and word counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cmd_count  <= '0;
            stat_word_count <= '0;
        end else begin
            if (pop)               stat_cmd_count  <= stat_cmd_count + 32'd1;
            if (ddr_rd_data_valid) stat_word_count <= stat_word_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_rd_cmd_responder.sv
// Bench for ddr_rd_cmd_responder: scoreboard of expected addresses/words filled by the stimulus,
// drained by a negedge monitor; includes a fixed-latency memory model returning a word derived from the address.
// Directed scenarios followed by randomized command traffic.
module tb_ddr_rd_cmd_responder;

    localparam int DW    = 256;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ddr_cmd_valid;
    logic [31:0]   ddr_cmd_base_adr;
    logic [15:0]   ddr_cmd_length;
    logic          ddr_cmd_ready;
    logic          mem_rd_en;
    logic [31:0]   mem_rd_adr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] ddr_rd_data;
    logic          ddr_rd_data_valid;
    logic          cmd_err;
    logic          busy;

    ddr_rd_cmd_responder #(
        .CMD_FIFO_DEPTH(DEPTH),
        .MEM_LATENCY(LAT),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ddr_cmd_valid(ddr_cmd_valid),
        .ddr_cmd_base_adr(ddr_cmd_base_adr),
        .ddr_cmd_length(ddr_cmd_length),
        .ddr_cmd_ready(ddr_cmd_ready),
        .mem_rd_en(mem_rd_en),
        .mem_rd_adr(mem_rd_adr),
        .mem_rd_data(mem_rd_data),
        .ddr_rd_data(ddr_rd_data),
        .ddr_rd_data_valid(ddr_rd_data_valid),
        .cmd_err(cmd_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    int exp_err = 0, seen_err = 0, words_seen = 0;
    int first_en = -1, last_en = -1, en_cnt = 0, first_vld = -1;

    function automatic logic [DW-1:0] mem_word(logic [31:0] a);
        return {{7{a ^ 32'hC3C3_3C3C}}, a};
    endfunction

    task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // memory model: word for the address presented exactly LAT cycles earlier
    logic [31:0] mp [LAT];
    initial begin
        for (int i = 0; i < LAT; i++) mp[i] = '0;
        forever begin
            @(posedge clk);
            mp[0] <= mem_rd_adr;
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mem_rd_data = mem_word(mp[LAT-1]);

    // cycle counter: value k seen at a negedge means we are in the cycle after edge k
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: compare every issued address and every returned word against the scoreboard
    initial forever begin
        @(negedge clk);
        if (mem_rd_en) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
            if (exp_adr_q.size() == 0) chk("unexpected_mem_rd_en", DW'(1), DW'(0));
            else chk("mem_rd_adr", DW'(mem_rd_adr), DW'(exp_adr_q.pop_front()));
        end
        if (ddr_rd_data_valid) begin
            if (first_vld < 0) first_vld = cyc;
            words_seen++;
            if (exp_dat_q.size() == 0) chk("unexpected_rd_data_valid", DW'(1), DW'(0));
            else chk("ddr_rd_data", ddr_rd_data, mem_word(exp_dat_q.pop_front()));
        end
        if (cmd_err) seen_err++;
    end

    // offer one command, hold it until accepted; reference model records the expected words
    task automatic send(input logic [31:0] b, input logic [15:0] l, output int t_acc, output int stalls);
        int budget;
        budget = 0;
        stalls = 0;
        @(negedge clk);
        ddr_cmd_valid    = 1'b1;
        ddr_cmd_base_adr = b;
        ddr_cmd_length   = l;
        while (!ddr_cmd_ready && budget < 200) begin
            @(negedge clk);
            stalls++;
            budget++;
        end
        if (!ddr_cmd_ready) begin
            chk("cmd_accept_timeout", DW'(0), DW'(1));
            ddr_cmd_valid = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc + 1;
        for (int i = 0; i < int'(l); i++) begin
            exp_adr_q.push_back(b + 32'(i));
            exp_dat_q.push_back(b + 32'(i));
        end
        if (l == 16'd0) exp_err++;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ddr_cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        ddr_cmd_valid = 1'b0;
        while ((exp_adr_q.size() != 0 || exp_dat_q.size() != 0 || busy) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        repeat (LAT + 3) @(negedge clk);
        chk({tag, "_queues_empty"}, DW'(exp_adr_q.size() + exp_dat_q.size()), DW'(0));
        chk({tag, "_busy_idle"}, DW'(busy), DW'(0));
        chk({tag, "_cmd_err_count"}, DW'(seen_err), DW'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, s, t1, st6, w0;
        reset            = 1'b0;
        ddr_cmd_valid    = 1'b0;
        ddr_cmd_base_adr = '0;
        ddr_cmd_length   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", DW'(ddr_cmd_ready), DW'(1));
        chk("rst_mem_rd_en", DW'(mem_rd_en), DW'(0));
        chk("rst_mem_rd_adr", DW'(mem_rd_adr), DW'(0));
        chk("rst_rd_valid", DW'(ddr_rd_data_valid), DW'(0));
        chk("rst_rd_data", ddr_rd_data, DW'(0));
        chk("rst_cmd_err", DW'(cmd_err), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single burst: latency of first issue and first return
        first_en = -1; first_vld = -1;
        send(32'h100, 16'd5, t, s);
        drain("single");
        chk("single_first_mem_rd_en_cycle", DW'(first_en), DW'(t + 2));
        chk("single_first_valid_cycle", DW'(first_vld), DW'(t + 3 + LAT));

        // back-to-back commands: no bubble on the memory port
        en_cnt = 0; first_en = -1;
        send(32'h0, 16'd3, t, s);
        send(32'h40, 16'd2, t, s);
        drain("b2b");
        chk("b2b_issue_count", DW'(en_cnt), DW'(5));
        chk("b2b_no_bubble", DW'(last_en - first_en + 1), DW'(5));

        // fill the FIFO: 6th offered command finds it full and waits one cycle
        send(32'h1000, 16'd4, t1, s);
        for (int k = 1; k < 5; k++) send(32'h1000 + 32'(k * 16), 16'd4, t, s);
        send(32'h1050, 16'd4, t, st6);
        chk("full_stall_cycles", DW'(st6), DW'(1));
        chk("full_accept_cycle", DW'(t), DW'(t1 + 6));
        drain("full");

        // zero-length command in between
        send(32'h10, 16'd1, t, s);
        send(32'h20, 16'd0, t, s);
        send(32'h20, 16'd1, t, s);
        drain("zero_len");

        // address wrap
        send(32'hFFFF_FFFE, 16'd3, t, s);
        drain("wrap");

        // reset during the 3rd returned word of a length-8 burst
        send(32'h300, 16'd8, t, s);
        idle(1);
        while (cyc < t + 5 + 2) @(negedge clk);
        chk("mid_burst_3rd_word_present", DW'(ddr_rd_data_valid), DW'(1));
        #1 reset = 1'b0;
        #1;
        chk("async_rst_valid", DW'(ddr_rd_data_valid), DW'(0));
        chk("async_rst_mem_rd_en", DW'(mem_rd_en), DW'(0));
        chk("async_rst_busy", DW'(busy), DW'(0));
        chk("async_rst_ready", DW'(ddr_cmd_ready), DW'(1));
        exp_adr_q.delete();
        exp_dat_q.delete();
        repeat (4) begin
            @(negedge clk);
            chk("held_rst_valid", DW'(ddr_rd_data_valid), DW'(0));
        end
        reset = 1'b1;
        w0 = words_seen;
        send(32'h200, 16'd2, t, s);
        drain("post_reset");
        chk("post_reset_word_count", DW'(words_seen - w0), DW'(2));

        // randomized traffic with gaps, zero lengths and wrap-prone bases
        for (int n = 0; n < 40; n++) begin
            logic [31:0] b;
            logic [15:0] l;
            b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            l = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) l = 16'($urandom_range(10, 24));
            send(b, l, t, s);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
